// File: rtl/kestrel2_pkg.sv
// Shared Kestrel-2 definitions: video RAM geometry, arbiter state encoding
// and the CPU address-map constants used by the top-level decoder.
package kestrel2_pkg;

   localparam int unsigned VRAM_AW = 13;
   localparam int unsigned VRAM_DW = 16;

   typedef logic [VRAM_AW-1:0] vram_adr_t;
   typedef logic [VRAM_DW-1:0] vram_dat_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } vram_state_e;

   typedef enum logic {
      OWN_VID = 1'b0,
      OWN_CPU = 1'b1
   } vram_owner_e;

   // CPU data-bus map: bits [15:14] select the region, 2'b10 is video RAM.
   localparam int unsigned MAP_SEL_HI   = 15;
   localparam int unsigned MAP_SEL_LO   = 14;
   localparam logic [1:0]  MAP_VRAM_SEL = 2'b10;

   function automatic logic is_vram_adr(input logic [15:0] adr);
      return adr[MAP_SEL_HI:MAP_SEL_LO] == MAP_VRAM_SEL;
   endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of the CPU, video-fetch and RAM-side signals around the arbiter;
// signal names are those of the original flat port list.
interface vram_arbiter_if;
   import kestrel2_pkg::*;

   vram_adr_t cpu_adr_i;
   vram_dat_t cpu_dat_i;
   vram_dat_t cpu_dat_o;
   logic      cpu_we_i;
   logic      cpu_stb_i;
   logic      cpu_ack_o;

   vram_adr_t vid_adr_i;
   logic      vid_stb_i;
   vram_dat_t vid_dat_o;
   logic      vid_ack_o;

   vram_adr_t ram_adr_o;
   vram_dat_t ram_dat_o;
   vram_dat_t ram_dat_i;
   logic      ram_en_o;
   logic      ram_we_o;

   modport slave (
      input  cpu_adr_i, cpu_dat_i, cpu_we_i, cpu_stb_i,
      input  vid_adr_i, vid_stb_i,
      input  ram_dat_i,
      output cpu_dat_o, cpu_ack_o,
      output vid_dat_o, vid_ack_o,
      output ram_adr_o, ram_dat_o, ram_en_o, ram_we_o
   );

   modport master (
      output cpu_adr_i, cpu_dat_i, cpu_we_i, cpu_stb_i,
      output vid_adr_i, vid_stb_i,
      output ram_dat_i,
      input  cpu_dat_o, cpu_ack_o,
      input  vid_dat_o, vid_ack_o,
      input  ram_adr_o, ram_dat_o, ram_en_o, ram_we_o
   );

endinterface

// File: rtl/vram_arbiter.sv
// Video RAM port arbiter: video fetch has priority, but the CPU is granted
// after VID_BURST consecutive video grants made while it was waiting.
module vram_arbiter
   import kestrel2_pkg::*;
#(
   parameter int unsigned VID_BURST = 4
) (
   input  logic          sys_clk_i,
   input  logic          sys_res_i,
   vram_arbiter_if.slave bus_io
);

   localparam logic [3:0] BURST_LIM = 4'(VID_BURST);

   vram_state_e state_q, state_d;
   vram_owner_e own_q, own_d;
   vram_adr_t   adr_q, adr_d;
   vram_dat_t   wdat_q, wdat_d;
   logic        we_q, we_d;
   logic [3:0]  run_q, run_d;
   vram_dat_t   cpu_dat_q, cpu_dat_d;
   vram_dat_t   vid_dat_q, vid_dat_d;
   logic        grant_vid, grant_cpu;

   always_comb begin
      grant_vid = 1'b0;
      grant_cpu = 1'b0;
      if (state_q == ST_IDLE) begin
         if (bus_io.vid_stb_i && !(bus_io.cpu_stb_i && run_q >= BURST_LIM)) begin
            grant_vid = 1'b1;
         end else if (bus_io.cpu_stb_i) begin
            grant_cpu = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      own_d     = own_q;
      adr_d     = adr_q;
      wdat_d    = wdat_q;
      we_d      = we_q;
      run_d     = run_q;
      cpu_dat_d = cpu_dat_q;
      vid_dat_d = vid_dat_q;

      unique case (state_q)
         ST_IDLE: begin
            if (grant_vid) begin
               own_d   = OWN_VID;
               adr_d   = bus_io.vid_adr_i;
               we_d    = 1'b0;
               state_d = ST_ISSUE;
            end else if (grant_cpu) begin
               own_d   = OWN_CPU;
               adr_d   = bus_io.cpu_adr_i;
               wdat_d  = bus_io.cpu_dat_i;
               we_d    = bus_io.cpu_we_i;
               state_d = ST_ISSUE;
            end
            // Run length only counts video wins the CPU actually waited through.
            if (grant_cpu || !bus_io.cpu_stb_i) begin
               run_d = '0;
            end else if (grant_vid && run_q != '1) begin
               run_d = run_q + 4'd1;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            state_d = ST_ACK;
            if (own_q == OWN_CPU) begin
               cpu_dat_d = bus_io.ram_dat_i;
            end else begin
               vid_dat_d = bus_io.ram_dat_i;
            end
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk_i) begin
      if (sys_res_i) begin
         state_q   <= ST_IDLE;
         own_q     <= OWN_VID;
         adr_q     <= '0;
         wdat_q    <= '0;
         we_q      <= 1'b0;
         run_q     <= '0;
         cpu_dat_q <= '0;
         vid_dat_q <= '0;
      end else begin
         state_q   <= state_d;
         own_q     <= own_d;
         adr_q     <= adr_d;
         wdat_q    <= wdat_d;
         we_q      <= we_d;
         run_q     <= run_d;
         cpu_dat_q <= cpu_dat_d;
         vid_dat_q <= vid_dat_d;
      end
   end

   // RAM strobes come straight from the state so a write in ISSUE still
   // reaches the RAM on the same edge that a reset is sampled.
   assign bus_io.ram_en_o  = (state_q == ST_ISSUE);
   assign bus_io.ram_we_o  = (state_q == ST_ISSUE) && we_q;
   assign bus_io.ram_adr_o = adr_q;
   assign bus_io.ram_dat_o = wdat_q;

   assign bus_io.cpu_ack_o = (state_q == ST_ACK) && (own_q == OWN_CPU);
   assign bus_io.vid_ack_o = (state_q == ST_ACK) && (own_q == OWN_VID);
   assign bus_io.cpu_dat_o = cpu_dat_q;
   assign bus_io.vid_dat_o = vid_dat_q;

   a_one_ack: assert property (@(posedge sys_clk_i)
      !(bus_io.cpu_ack_o && bus_io.vid_ack_o));
   a_we_en: assert property (@(posedge sys_clk_i)
      bus_io.ram_we_o |-> bus_io.ram_en_o);

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: behavioural RAM, shadow memory and
// an expected-ack queue (port, data, cycle) consumed as acks appear.
module tb_vram_arbiter;
   import kestrel2_pkg::*;

   typedef struct {
      bit          is_cpu;
      logic [15:0] dat;
      bit          chk_dat;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          both_acks = 0;
   exp_t        exp_q[$];
   logic [15:0] mem    [0:8191];
   logic [15:0] shadow [0:8191];

   vram_arbiter_if bus ();

   vram_arbiter #(.VID_BURST(4)) dut (
      .sys_clk_i (clk),
      .sys_res_i (rst),
      .bus_io    (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.ram_en_o) begin
         if (bus.ram_we_o) mem[bus.ram_adr_o] <= bus.ram_dat_o;
         bus.ram_dat_i <= mem[bus.ram_adr_o];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (bus.cpu_ack_o && bus.vid_ack_o) both_acks++;
   endtask

   task automatic test_reset();
      bus.cpu_stb_i = 1'b0; bus.vid_stb_i = 1'b0; bus.cpu_we_i = 1'b0;
      bus.cpu_adr_i = '0;   bus.vid_adr_i = '0;   bus.cpu_dat_i = '0;
      rst = 1'b1;
      tick(); tick();
      checks++;
      if ({bus.cpu_ack_o, bus.vid_ack_o, bus.ram_en_o, bus.ram_we_o} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctl got %b want 0000",
                  {bus.cpu_ack_o, bus.vid_ack_o, bus.ram_en_o, bus.ram_we_o});
      end
      checks++;
      if ({bus.ram_adr_o, bus.ram_dat_o} !== 29'h0) begin
         errors++;
         $display("FAIL reset_ram got %h/%h want 0/0", bus.ram_adr_o, bus.ram_dat_o);
      end
      checks++;
      if ({bus.cpu_dat_o, bus.vid_dat_o} !== 32'h0) begin
         errors++;
         $display("FAIL reset_dat got %h/%h want 0/0", bus.cpu_dat_o, bus.vid_dat_o);
      end
      rst = 1'b0;
   endtask

   task automatic test_cpu_write_read();
      exp_t e;
      int   c0;
      bit   got;
      bit   we;
      for (int i = 0; i < 2; i++) begin
         we = (i == 0);
         bus.cpu_adr_i = 13'h0123;
         bus.cpu_dat_i = we ? 16'hBEEF : 16'h0000;
         bus.cpu_we_i  = we;
         bus.cpu_stb_i = 1'b1;
         c0 = cyc;
         exp_q.push_back('{is_cpu: 1'b1, dat: shadow[13'h0123], chk_dat: !we, cyc: c0 + 3});
         if (we) shadow[13'h0123] = 16'hBEEF;
         got = 1'b0;
         for (int n = 0; n < 10 && !got; n++) begin
            tick();
            if (cyc == c0 + 1) begin
               checks++;
               if ({bus.ram_en_o, bus.ram_we_o} !== {1'b1, we}) begin
                  errors++;
                  $display("FAIL wr_rd_issue en/we got %b want %b",
                           {bus.ram_en_o, bus.ram_we_o}, {1'b1, we});
               end
               checks++;
               if (bus.ram_adr_o !== 13'h0123 || (we && bus.ram_dat_o !== 16'hBEEF)) begin
                  errors++;
                  $display("FAIL wr_rd_issue adr/dat got %h/%h want 0123/beef",
                           bus.ram_adr_o, bus.ram_dat_o);
               end
            end
            if (bus.cpu_ack_o || bus.vid_ack_o) begin
               got = 1'b1;
               bus.cpu_stb_i = 1'b0;
               e = exp_q.pop_front();
               checks++;
               if ({bus.cpu_ack_o, bus.vid_ack_o} !== 2'b10) begin
                  errors++;
                  $display("FAIL wr_rd_port got %b want 10", {bus.cpu_ack_o, bus.vid_ack_o});
               end
               checks++;
               if (cyc !== e.cyc) begin
                  errors++;
                  $display("FAIL wr_rd_latency got %0d want %0d", cyc - c0, e.cyc - c0);
               end
               if (e.chk_dat) begin
                  checks++;
                  if (bus.cpu_dat_o !== e.dat) begin
                     errors++;
                     $display("FAIL wr_rd_data got %h want %h", bus.cpu_dat_o, e.dat);
                  end
               end
            end
         end
         checks++;
         if (!got) begin
            errors++;
            $display("FAIL wr_rd_timeout got no ack want ack");
            exp_q.delete();
            bus.cpu_stb_i = 1'b0;
         end
         tick();
      end
   endtask

   task automatic test_video_stream();
      exp_t e;
      int   nack;
      int   c0;
      bus.vid_adr_i = 13'h0000;
      bus.vid_stb_i = 1'b1;
      c0 = cyc;
      exp_q.push_back('{is_cpu: 1'b0, dat: shadow[0], chk_dat: 1'b1, cyc: c0 + 3});
      nack = 0;
      for (int n = 0; n < 60 && nack < 8; n++) begin
         tick();
         if (bus.cpu_ack_o || bus.vid_ack_o) begin
            e = exp_q.pop_front();
            checks++;
            if ({bus.cpu_ack_o, bus.vid_ack_o} !== 2'b01) begin
               errors++;
               $display("FAIL vid_port got %b want 01", {bus.cpu_ack_o, bus.vid_ack_o});
            end
            checks++;
            if (cyc !== e.cyc) begin
               errors++;
               $display("FAIL vid_spacing ack%0d got cycle %0d want %0d", nack, cyc, e.cyc);
            end
            checks++;
            if (bus.vid_dat_o !== e.dat) begin
               errors++;
               $display("FAIL vid_data ack%0d got %h want %h", nack, bus.vid_dat_o, e.dat);
            end
            nack++;
            if (nack < 8) begin
               bus.vid_adr_i = 13'(nack);
               exp_q.push_back('{is_cpu: 1'b0, dat: shadow[nack], chk_dat: 1'b1, cyc: cyc + 4});
            end else begin
               bus.vid_stb_i = 1'b0;
            end
         end
      end
      checks++;
      if (nack != 8) begin
         errors++;
         $display("FAIL vid_count got %0d want 8", nack);
         exp_q.delete();
         bus.vid_stb_i = 1'b0;
      end
      tick();
   endtask

   task automatic test_contention();
      exp_t        e;
      logic [9:0]  pat;
      logic [12:0] cadr;
      logic [12:0] vadr;
      int          nack;
      int          c0;
      int          b0;
      pat  = 10'h210;  // bit i set = grant i goes to the CPU
      cadr = 13'h0200;
      vadr = 13'h0300;
      bus.cpu_adr_i = cadr; bus.cpu_we_i = 1'b0; bus.cpu_stb_i = 1'b1;
      bus.vid_adr_i = vadr; bus.vid_stb_i = 1'b1;
      c0 = cyc;
      b0 = both_acks;
      for (int i = 0; i < 10; i++)
         exp_q.push_back('{is_cpu: pat[i], dat: 16'h0, chk_dat: 1'b0, cyc: c0 + 3 + 4 * i});
      nack = 0;
      for (int n = 0; n < 80 && nack < 10; n++) begin
         tick();
         if (bus.cpu_ack_o || bus.vid_ack_o) begin
            e = exp_q.pop_front();
            checks++;
            if ({bus.cpu_ack_o, bus.vid_ack_o} !== {e.is_cpu, !e.is_cpu}) begin
               errors++;
               $display("FAIL cont_order grant%0d got cpu/vid %b want %b", nack,
                        {bus.cpu_ack_o, bus.vid_ack_o}, {e.is_cpu, !e.is_cpu});
            end
            checks++;
            if (cyc !== e.cyc) begin
               errors++;
               $display("FAIL cont_timing grant%0d got cycle %0d want %0d", nack, cyc, e.cyc);
            end
            if (bus.cpu_ack_o) begin
               checks++;
               if (bus.cpu_dat_o !== shadow[cadr]) begin
                  errors++;
                  $display("FAIL cont_cpu_data got %h want %h", bus.cpu_dat_o, shadow[cadr]);
               end
               cadr = cadr + 13'd1;
               bus.cpu_adr_i = cadr;
            end
            if (bus.vid_ack_o) begin
               checks++;
               if (bus.vid_dat_o !== shadow[vadr]) begin
                  errors++;
                  $display("FAIL cont_vid_data got %h want %h", bus.vid_dat_o, shadow[vadr]);
               end
               vadr = vadr + 13'd1;
               bus.vid_adr_i = vadr;
            end
            nack++;
            if (nack == 10) begin
               bus.cpu_stb_i = 1'b0;
               bus.vid_stb_i = 1'b0;
            end
         end
      end
      checks++;
      if (nack != 10) begin
         errors++;
         $display("FAIL cont_count got %0d want 10", nack);
         exp_q.delete();
         bus.cpu_stb_i = 1'b0;
         bus.vid_stb_i = 1'b0;
      end
      checks++;
      if (both_acks != b0) begin
         errors++;
         $display("FAIL cont_both_acks got %0d want 0", both_acks - b0);
      end
      tick();
   endtask

   task automatic test_input_change();
      exp_t e;
      int   c0;
      bit   got;
      bus.cpu_adr_i = 13'h0010;
      bus.cpu_we_i  = 1'b0;
      bus.cpu_stb_i = 1'b1;
      c0 = cyc;
      exp_q.push_back('{is_cpu: 1'b1, dat: shadow[13'h0010], chk_dat: 1'b1, cyc: c0 + 3});
      got = 1'b0;
      for (int n = 0; n < 10 && !got; n++) begin
         tick();
         if (cyc >= c0 + 1 && cyc <= c0 + 3) begin
            checks++;
            if (bus.ram_adr_o !== 13'h0010) begin
               errors++;
               $display("FAIL chg_adr cycle %0d got %h want 0010", cyc - c0, bus.ram_adr_o);
            end
         end
         if (cyc == c0 + 1) begin
            checks++;
            if (bus.ram_we_o !== 1'b0) begin
               errors++;
               $display("FAIL chg_we got %b want 0", bus.ram_we_o);
            end
            bus.cpu_adr_i = 13'h0020;
            bus.cpu_dat_i = 16'hFFFF;
            bus.cpu_we_i  = 1'b1;
         end
         if (bus.cpu_ack_o || bus.vid_ack_o) begin
            got = 1'b1;
            bus.cpu_stb_i = 1'b0;
            bus.cpu_we_i  = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (cyc !== e.cyc || bus.cpu_ack_o !== 1'b1) begin
               errors++;
               $display("FAIL chg_ack got cycle %0d cpu_ack %b want cycle %0d cpu_ack 1",
                        cyc - c0, bus.cpu_ack_o, e.cyc - c0);
            end
            checks++;
            if (bus.cpu_dat_o !== e.dat) begin
               errors++;
               $display("FAIL chg_data got %h want %h", bus.cpu_dat_o, e.dat);
            end
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL chg_timeout got no ack want ack");
         exp_q.delete();
         bus.cpu_stb_i = 1'b0;
         bus.cpu_we_i  = 1'b0;
      end
      checks++;
      if (mem[13'h0020] !== shadow[13'h0020]) begin
         errors++;
         $display("FAIL chg_no_write got %h want %h", mem[13'h0020], shadow[13'h0020]);
      end
      tick();
   endtask

   task automatic test_reset_issue();
      exp_t e;
      int   c0;
      int   acks;
      bit   got;
      bus.cpu_adr_i = 13'h0040;
      bus.cpu_dat_i = 16'h1234;
      bus.cpu_we_i  = 1'b1;
      bus.cpu_stb_i = 1'b1;
      tick();
      checks++;
      if ({bus.ram_en_o, bus.ram_we_o} !== 2'b11) begin
         errors++;
         $display("FAIL rst_issue_state got %b want 11", {bus.ram_en_o, bus.ram_we_o});
      end
      rst = 1'b1;
      shadow[13'h0040] = 16'h1234;
      tick();
      checks++;
      if ({bus.cpu_ack_o, bus.vid_ack_o, bus.ram_en_o, bus.ram_we_o} !== 4'b0000 ||
          {bus.ram_adr_o, bus.ram_dat_o} !== 29'h0 ||
          {bus.cpu_dat_o, bus.vid_dat_o} !== 32'h0) begin
         errors++;
         $display("FAIL rst_issue_zero got ack %b%b en %b we %b adr %h wd %h cd %h vd %h want all 0",
                  bus.cpu_ack_o, bus.vid_ack_o, bus.ram_en_o, bus.ram_we_o,
                  bus.ram_adr_o, bus.ram_dat_o, bus.cpu_dat_o, bus.vid_dat_o);
      end
      rst = 1'b0;
      bus.cpu_stb_i = 1'b0;
      bus.cpu_we_i  = 1'b0;
      acks = 0;
      for (int n = 0; n < 6; n++) begin
         tick();
         if (bus.cpu_ack_o) acks++;
      end
      checks++;
      if (acks != 0) begin
         errors++;
         $display("FAIL rst_issue_noack got %0d acks want 0", acks);
      end
      bus.cpu_adr_i = 13'h0040;
      bus.cpu_stb_i = 1'b1;
      c0 = cyc;
      exp_q.push_back('{is_cpu: 1'b1, dat: shadow[13'h0040], chk_dat: 1'b1, cyc: c0 + 3});
      got = 1'b0;
      for (int n = 0; n < 10 && !got; n++) begin
         tick();
         if (bus.cpu_ack_o || bus.vid_ack_o) begin
            got = 1'b1;
            bus.cpu_stb_i = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (bus.cpu_dat_o !== e.dat || bus.cpu_ack_o !== 1'b1) begin
               errors++;
               $display("FAIL rst_issue_readback got %h ack %b want %h ack 1",
                        bus.cpu_dat_o, bus.cpu_ack_o, e.dat);
            end
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL rst_issue_timeout got no ack want ack");
         exp_q.delete();
         bus.cpu_stb_i = 1'b0;
      end
      tick();
   endtask

   task automatic test_reset_contention(input int vgrants);
      exp_t e;
      int   nv;
      int   c0;
      bit   got;
      bus.cpu_adr_i = 13'h0400; bus.cpu_we_i = 1'b0; bus.cpu_stb_i = 1'b1;
      bus.vid_adr_i = 13'h0500; bus.vid_stb_i = 1'b1;
      nv = 0;
      for (int n = 0; n < 60 && nv < vgrants; n++) begin
         tick();
         if (bus.cpu_ack_o || bus.vid_ack_o) begin
            checks++;
            if (bus.vid_ack_o !== 1'b1) begin
               errors++;
               $display("FAIL rstc_pre grant%0d got cpu/vid %b want 01", nv,
                        {bus.cpu_ack_o, bus.vid_ack_o});
            end
            nv++;
         end
      end
      checks++;
      if (nv != vgrants) begin
         errors++;
         $display("FAIL rstc_pre_count got %0d want %0d", nv, vgrants);
      end
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      c0 = cyc;
      exp_q.push_back('{is_cpu: 1'b0, dat: shadow[13'h0500], chk_dat: 1'b1, cyc: c0 + 3});
      got = 1'b0;
      for (int n = 0; n < 10 && !got; n++) begin
         tick();
         if (bus.cpu_ack_o || bus.vid_ack_o) begin
            got = 1'b1;
            bus.cpu_stb_i = 1'b0;
            bus.vid_stb_i = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if ({bus.cpu_ack_o, bus.vid_ack_o} !== 2'b01 || cyc !== e.cyc) begin
               errors++;
               $display("FAIL rstc_first run%0d got cpu/vid %b at %0d want 01 at %0d", vgrants,
                        {bus.cpu_ack_o, bus.vid_ack_o}, cyc - c0, e.cyc - c0);
            end
            checks++;
            if (bus.vid_dat_o !== e.dat) begin
               errors++;
               $display("FAIL rstc_data got %h want %h", bus.vid_dat_o, e.dat);
            end
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL rstc_timeout got no ack want ack");
         exp_q.delete();
         bus.cpu_stb_i = 1'b0;
         bus.vid_stb_i = 1'b0;
      end
      tick(); tick();
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) begin
         mem[i]    = 16'h5A5A ^ 16'(i * 13);
         shadow[i] = 16'h5A5A ^ 16'(i * 13);
      end
      test_reset();
      test_cpu_write_read();
      test_video_stream();
      test_contention();
      test_input_change();
      test_reset_issue();
      test_reset_contention(3);
      test_reset_contention(4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
